hazard_scoreboard: RTL and testbench

- Producer-side companion to the EX/MEM/WB bypass network.
- Tracks each in-flight destination register and how many cycles remain until its result reaches a forwardable stage. From this it decides in ID whether an instruction can issue or must stall.
- Covers the cases forwarding alone cannot cover: load-use, multi-cycle multiply, WAW ordering, and the multiplier structural hazard.
- Sits between decode and the ID/EX pipeline register. It drives the stall to PC/IF-ID and the bubble insert to ID/EX.

---
 rtl/pipeline_pkg.sv | 27 ++
 rtl/sb_entry.sv | 23 ++
 rtl/hazard_scoreboard.sv | 70 +++++++
 tb/tb_hazard_scoreboard.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and latency classes for the ID-stage hazard logic.
// No logic of its own; latency helper is purely combinational.
package pipeline_pkg;

    localparam int REG_W    = 5;
    localparam int NREG     = 32;
    localparam int ZERO_REG = 31;
    localparam int LOAD_LAT = 1;
    localparam int MUL_LAT  = 3;
    localparam int CW       = 2;

    typedef enum logic [1:0] {
        LAT_ALU,
        LAT_LOAD,
        LAT_MUL
    } lat_class_t;

    // Cycles a result must still wait before the bypass network can forward it.
    function automatic logic [CW-1:0] lat_cycles(input lat_class_t cls);
        case (cls)
            LAT_MUL:  lat_cycles = CW'(MUL_LAT);
            LAT_LOAD: lat_cycles = CW'(LOAD_LAT);
            default:  lat_cycles = '0;
        endcase
    endfunction

endpackage

// File: rtl/sb_entry.sv
// Saturating down-counter for one scoreboard slot, with a load that overrides the decrement.
// Latency: 1 cycle from load to count; no backpressure, updates every clock.
module sb_entry
    import pipeline_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage scoreboard: stalls on load-use, multiply RAW, WAW ordering and multiplier occupancy.
// Latency: stall/issue are combinational from state and ID inputs; stall holds PC/IF-ID and bubbles ID/EX.
module hazard_scoreboard
    import pipeline_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_is_mul,
    input  logic             flush,
    output logic             stall,
    output logic             issue,
    output logic             mul_busy,
    output logic [NREG-1:0]  pending_mask
);

    logic [CW-1:0] cnt [NREG];
    logic [CW-1:0] mul_cnt;
    logic [CW-1:0] new_lat;
    lat_class_t    lat_class;
    logic          raw_a, raw_b, waw, struct_haz, rd_tracked;

    always_comb begin
        lat_class = LAT_ALU;
        if (id_is_mul)        lat_class = LAT_MUL;
        else if (id_mem_read) lat_class = LAT_LOAD;
    end

    assign new_lat    = lat_cycles(lat_class);
    assign rd_tracked = id_reg_write && (id_rd != REG_W'(ZERO_REG));

    assign raw_a      = id_use_rs && (id_rs != REG_W'(ZERO_REG)) && (cnt[id_rs] != '0);
    assign raw_b      = id_use_rt && (id_rt != REG_W'(ZERO_REG)) && (cnt[id_rt] != '0);
    // An older write still in flight longer than ours would land after it.
    assign waw        = rd_tracked && (cnt[id_rd] > new_lat);
    assign struct_haz = id_is_mul && (mul_cnt != '0);

    // Reset masks the outputs so a half-reset pipeline never advances.
    assign stall = !rst && id_valid && !flush && (raw_a | raw_b | waw | struct_haz);
    assign issue = !rst && id_valid && !flush && !stall;

    for (genvar r = 0; r < NREG; r++) begin : g_reg
        sb_entry u_entry (
            .clk      (clk),
            .rst      (rst),
            .load     (issue && rd_tracked && (id_rd == REG_W'(r))),
            .load_val (new_lat),
            .cnt      (cnt[r])
        );
        assign pending_mask[r] = (cnt[r] != '0);
    end

    sb_entry u_mul (
        .clk      (clk),
        .rst      (rst),
        .load     (issue && id_is_mul),
        .load_val (CW'(MUL_LAT)),
        .cnt      (mul_cnt)
    );

    assign mul_busy = (mul_cnt != '0);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_use_rs, id_use_rt, id_reg_write, id_mem_read, id_is_mul;
    logic        flush;
    logic        stall, issue, mul_busy;
    logic [31:0] pending_mask;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .id_is_mul    (id_is_mul),
        .flush        (flush),
        .stall        (stall),
        .issue        (issue),
        .mul_busy     (mul_busy),
        .pending_mask (pending_mask)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // v, rs, use_rs, rt, use_rt, rd, reg_write, mem_read, is_mul, flush
    task automatic set_id(input logic v, input int rs, input logic urs, input int rt, input logic urt,
                          input int rd, input logic we, input logic mr, input logic mul, input logic fl);
        id_valid = v; id_rs = 5'(rs); id_use_rs = urs; id_rt = 5'(rt); id_use_rt = urt;
        id_rd = 5'(rd); id_reg_write = we; id_mem_read = mr; id_is_mul = mul; flush = fl;
        #1;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        set_id(1, 1, 1, 2, 1, 3, 1, 0, 0, 0);
        check("rst_issue", 32'(issue), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_pending", pending_mask, 0);
        check("rst_mul_busy", 32'(mul_busy), 0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        next_cycle();

        // load r5, then add r6,r5,r1: one bubble
        set_id(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        check("ld_issue", 32'(issue), 1);
        next_cycle();
        set_id(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        check("lu_stall", 32'(stall), 1);
        check("lu_noissue", 32'(issue), 0);
        check("lu_pend5", 32'(pending_mask[5]), 1);
        next_cycle();
        check("lu_stall_clr", 32'(stall), 0);
        check("lu_issue", 32'(issue), 1);
        check("lu_pend5_clr", 32'(pending_mask[5]), 0);
        next_cycle();

        // ALU r7 then add r8,r7,r7: forwarding suffices
        set_id(1, 1, 1, 2, 1, 7, 1, 0, 0, 0);
        check("alu_issue", 32'(issue), 1);
        next_cycle();
        set_id(1, 7, 1, 7, 1, 8, 1, 0, 0, 0);
        check("alu_dep_stall", 32'(stall), 0);
        check("alu_dep_issue", 32'(issue), 1);
        check("alu_pending", pending_mask, 0);
        next_cycle();

        // mul r3, then reader using r3 as both sources: stalls t+1..t+3
        set_id(1, 1, 1, 2, 1, 3, 1, 0, 1, 0);
        check("mul_issue", 32'(issue), 1);
        next_cycle();
        set_id(1, 3, 1, 3, 1, 10, 1, 0, 0, 0);
        check("mul_pend3", 32'(pending_mask[3]), 1);
        check("mul_busy_on", 32'(mul_busy), 1);
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("mul_raw_stall_t%0d", i), 32'(stall), 1);
            next_cycle();
        end
        check("mul_raw_issue", 32'(issue), 1);
        check("mul_busy_off", 32'(mul_busy), 0);
        next_cycle();

        // mul r12 then mul r13: structural stall until mul_busy falls
        set_id(1, 1, 1, 2, 1, 12, 1, 0, 1, 0);
        check("mul2_first_issue", 32'(issue), 1);
        next_cycle();
        set_id(1, 1, 1, 2, 1, 13, 1, 0, 1, 0);
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("struct_stall_t%0d", i), 32'(stall), 1);
            next_cycle();
        end
        check("struct_issue", 32'(issue), 1);
        next_cycle();
        idle();
        for (int i = 0; i < 3; i++) next_cycle();
        check("mul_drain_pending", pending_mask, 0);
        check("mul_drain_busy", 32'(mul_busy), 0);

        // load r9 then ALU write r9: WAW one cycle
        set_id(1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
        next_cycle();
        set_id(1, 1, 1, 0, 0, 9, 1, 0, 0, 0);
        check("waw_stall", 32'(stall), 1);
        next_cycle();
        check("waw_issue", 32'(issue), 1);
        next_cycle();

        // r31 is never tracked
        set_id(1, 0, 0, 0, 0, 31, 1, 1, 0, 0);
        check("r31_ld_issue", 32'(issue), 1);
        next_cycle();
        set_id(1, 31, 1, 31, 1, 31, 1, 1, 0, 0);
        check("r31_stall", 32'(stall), 0);
        check("r31_pend", 32'(pending_mask[31]), 0);
        next_cycle();

        // rd==rs with rs pending: RAW stall first, re-marked only at issue
        set_id(1, 0, 0, 0, 0, 20, 1, 1, 0, 0);
        next_cycle();
        set_id(1, 20, 1, 1, 1, 20, 1, 0, 0, 0);
        check("rdrs_stall", 32'(stall), 1);
        next_cycle();
        check("rdrs_issue", 32'(issue), 1);
        next_cycle();
        idle();
        check("rdrs_pend_clr", 32'(pending_mask[20]), 0);

        // flushed dependent mul: no stall, no issue, no state change
        set_id(1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
        next_cycle();
        set_id(1, 2, 1, 0, 0, 14, 1, 0, 1, 1);
        check("flush_stall", 32'(stall), 0);
        check("flush_issue", 32'(issue), 0);
        next_cycle();
        set_id(1, 1, 1, 0, 0, 15, 1, 0, 0, 0);
        check("post_flush_issue", 32'(issue), 1);
        check("flush_no_pend14", 32'(pending_mask[14]), 0);
        check("flush_no_mul", 32'(mul_busy), 0);
        next_cycle();

        // id_valid=0: no stall/issue, counters still drain
        set_id(1, 0, 0, 0, 0, 21, 1, 1, 0, 0);
        next_cycle();
        set_id(0, 21, 1, 0, 0, 22, 1, 0, 0, 0);
        check("novalid_stall", 32'(stall), 0);
        check("novalid_issue", 32'(issue), 0);
        check("novalid_pend21", 32'(pending_mask[21]), 1);
        next_cycle();
        set_id(1, 21, 1, 0, 0, 22, 1, 0, 0, 0);
        check("novalid_drained_issue", 32'(issue), 1);
        next_cycle();

        // reset mid-stall with cnt[4]=3
        set_id(1, 0, 0, 0, 0, 4, 1, 0, 1, 0);
        next_cycle();
        set_id(1, 4, 1, 0, 0, 23, 1, 0, 0, 0);
        check("prerst_stall", 32'(stall), 1);
        check("prerst_pend4", 32'(pending_mask[4]), 1);
        rst = 1'b1;
        #1;
        check("midrst_pending", pending_mask, 0);
        check("midrst_stall", 32'(stall), 0);
        check("midrst_issue", 32'(issue), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("postrst_issue", 32'(issue), 1);
        check("postrst_mul_busy", 32'(mul_busy), 0);
        next_cycle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
